// File: rtl/writeback_queue_if.sv
// Bundle of handshake, bank-write and forwarding signals for writeback_queue.
// master = producer/bank side (drives results, hold, query), slave = the queue.
// Handshake: a result transfers on a rising edge where its valid and ready are
// both high; ready depends only on the registered occupancy, never on valid of
// the same channel nor on a pop in the same cycle.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          wb_hold;
    logic [AW-1:0] write_addr;
    logic          reg_write;
    logic [DW-1:0] data_in;
    logic [CW-1:0] pending;
    logic          empty;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output wb_hold, fwd_addr,
        input  alu_ready, mem_ready,
        input  write_addr, reg_write, data_in,
        input  pending, empty, fwd_hit, fwd_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  wb_hold, fwd_addr,
        output alu_ready, mem_ready,
        output write_addr, reg_write, data_in,
        output pending, empty, fwd_hit, fwd_data
    );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue in front of the 32x32 register bank.
// Accepts ALU and load results (ALU first when both arrive), buffers them in
// order, and issues at most one registered bank write per cycle.
// Optional macro WBQ_FWD_EN builds a forwarding lookup over queued entries and
// the in-flight output register; without it fwd_hit/fwd_data are tied to 0.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic               clk,
    input logic               rst,
    writeback_queue_if.slave  io_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic          r_reg_write;
    logic [AW-1:0] r_write_addr;
    logic [DW-1:0] r_data_in;

    logic          w_alu_ready;
    logic          w_mem_ready;
    logic          w_alu_push;
    logic          w_mem_push;
    logic          w_pop;
    logic [PW-1:0] w_mem_slot;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;

    // Ready from registered count only; mem reserves room behind a same-cycle ALU push.
    assign w_alu_ready = (r_count < CW'(DEPTH));
    assign w_mem_ready = io_bus.alu_valid ? (r_count < CW'(DEPTH - 1))
                                          : (r_count < CW'(DEPTH));
    assign w_alu_push  = io_bus.alu_valid && w_alu_ready;
    assign w_mem_push  = io_bus.mem_valid && w_mem_ready;
    assign w_pop       = (r_count != '0) && !io_bus.wb_hold;
    // The load result lands one slot behind the ALU result when both are taken.
    assign w_mem_slot  = w_alu_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

    // Entry storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_fifo_addr[r_wr_ptr] <= io_bus.alu_addr;
            r_fifo_data[r_wr_ptr] <= io_bus.alu_data;
        end
        if (w_mem_push) begin
            r_fifo_addr[w_mem_slot] <= io_bus.mem_addr;
            r_fifo_data[w_mem_slot] <= io_bus.mem_data;
        end
    end

    // Occupancy and pointers; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + CW'(w_alu_push) + CW'(w_mem_push) - CW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_alu_push) + PW'(w_mem_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        end
    end

    // Bank write port: head moves out on a pop, otherwise address/data hold and write drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_data_in    <= '0;
        end else if (w_pop) begin
            r_reg_write  <= 1'b1;
            r_write_addr <= r_fifo_addr[r_rd_ptr];
            r_data_in    <= r_fifo_data[r_rd_ptr];
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

`ifdef WBQ_FWD_EN
    // Forwarding search oldest-to-newest so the newest match overrides older ones.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (r_reg_write && (r_write_addr == io_bus.fwd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data_in;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_fifo_addr[r_rd_ptr + PW'(k)] == io_bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[r_rd_ptr + PW'(k)];
            end
        end
    end
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^io_bus.fwd_addr;
    assign w_fwd_hit    = 1'b0;
    assign w_fwd_data   = '0;
`endif

    assign io_bus.alu_ready  = w_alu_ready;
    assign io_bus.mem_ready  = w_mem_ready;
    assign io_bus.reg_write  = r_reg_write;
    assign io_bus.write_addr = r_write_addr;
    assign io_bus.data_in    = r_data_in;
    assign io_bus.pending    = r_count;
    assign io_bus.empty      = (r_count == '0) && !r_reg_write;
    assign io_bus.fwd_hit    = w_fwd_hit;
    assign io_bus.fwd_data   = w_fwd_data;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single write, dual push,
// fill under hold, back-to-back with mem refusal, reset mid-drain, forwarding.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 3;
`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] wr_log[$];
    logic [DW-1:0]    bank [32];

    // Clock / reset
    always #5 clk = ~clk;

    writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Bank model: records every write the queue issues, in order
    always @(posedge clk) begin
        if (bus.reg_write === 1'b1) begin
            wr_log.push_back({bus.write_addr, bus.data_in});
            bank[bus.write_addr] <= bus.data_in;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        bus.wb_hold = 1'b0;
        bus.fwd_addr = '0;
        #2;
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write got %b want 0", bus.reg_write); end
        checks++; if (bus.pending !== CW'(0)) begin errors++; $display("FAIL rst_pending got %0d want 0", bus.pending); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus.empty); end
        checks++; if (bus.write_addr !== 5'd0) begin errors++; $display("FAIL rst_write_addr got %0d want 0", bus.write_addr); end
        checks++; if (bus.data_in !== 32'h0) begin errors++; $display("FAIL rst_data_in got %h want 0", bus.data_in); end
        checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b%b want 11", bus.alu_ready, bus.mem_ready); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.reg_write !== 1'b0 || bus.pending !== CW'(0)) begin errors++; $display("FAIL rst_release got rw=%b pend=%0d want 0/0", bus.reg_write, bus.pending); end
    endtask

    task automatic test_single_write;
        wr_log.delete();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hDEADBEEF;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.alu_ready); end
        tick();
        idle_inputs();
        checks++; if (bus.pending !== CW'(1) || bus.reg_write !== 1'b0) begin errors++; $display("FAIL single_queued got pend=%0d rw=%b want 1/0", bus.pending, bus.reg_write); end
        tick();
        checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL single_rw got %b want 1", bus.reg_write); end
        checks++; if (bus.write_addr !== 5'd3) begin errors++; $display("FAIL single_addr got %0d want 3", bus.write_addr); end
        checks++; if (bus.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", bus.data_in); end
        checks++; if (bus.pending !== CW'(0) || bus.empty !== 1'b0) begin errors++; $display("FAIL single_inflight got pend=%0d empty=%b want 0/0", bus.pending, bus.empty); end
        tick();
        checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL single_done got rw=%b empty=%b want 0/1", bus.reg_write, bus.empty); end
        checks++; if (wr_log.size() != 1 || wr_log[0] !== {5'd3, 32'hDEADBEEF}) begin errors++; $display("FAIL single_log got size %0d want 1 write", wr_log.size()); end
    endtask

    task automatic test_simultaneous;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd5; bus.mem_data = 32'h22;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL simul_mem_ready got %b want 1", bus.mem_ready); end
        tick();
        idle_inputs();
        checks++; if (bus.pending !== CW'(2)) begin errors++; $display("FAIL simul_pending got %0d want 2", bus.pending); end
        tick();
        checks++; if (bus.reg_write !== 1'b1 || bus.data_in !== 32'h11 || bus.pending !== CW'(1)) begin errors++; $display("FAIL simul_first got rw=%b data=%h pend=%0d want 1/11/1", bus.reg_write, bus.data_in, bus.pending); end
        tick();
        checks++; if (bus.reg_write !== 1'b1 || bus.data_in !== 32'h22 || bus.write_addr !== 5'd5) begin errors++; $display("FAIL simul_second got rw=%b addr=%0d data=%h want 1/5/22", bus.reg_write, bus.write_addr, bus.data_in); end
        tick();
        checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL simul_done got rw=%b empty=%b want 0/1", bus.reg_write, bus.empty); end
        checks++; if (bank[5] !== 32'h22) begin errors++; $display("FAIL simul_bank_r5 got %h want 22", bank[5]); end
    endtask

    task automatic test_fill_hold;
        logic [AW+DW-1:0] exp;
        exp_q.delete();
        bus.wb_hold = 1'b1;
        checks++; if (bus.write_addr !== 5'd5 || bus.data_in !== 32'h22) begin errors++; $display("FAIL hold_outputs got addr=%0d data=%h want 5/22", bus.write_addr, bus.data_in); end
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = AW'(10 + i); bus.alu_data = DW'(32'h100 + i);
            exp_q.push_back({AW'(10 + i), DW'(32'h100 + i)});
            if (i == 3) begin
                bus.mem_valid = 1'b1; bus.mem_addr = 5'd30; bus.mem_data = 32'hBAD;
                checks++; if (bus.pending !== CW'(3)) begin errors++; $display("FAIL fill_pending3 got %0d want 3", bus.pending); end
                checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready3 got alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready); end
            end
            tick();
        end
        bus.mem_valid = 1'b0;
        bus.alu_addr = 5'd31; bus.alu_data = 32'hBAD;
        checks++; if (bus.pending !== CW'(4)) begin errors++; $display("FAIL fill_pending4 got %0d want 4", bus.pending); end
        checks++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got alu=%b mem=%b want 0/0", bus.alu_ready, bus.mem_ready); end
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL fill_hold_rw got %b want 0", bus.reg_write); end
        tick();
        idle_inputs();
        checks++; if (bus.pending !== CW'(4)) begin errors++; $display("FAIL fill_no_overflow got %0d want 4", bus.pending); end
        bus.wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = exp_q.pop_front();
            checks++; if (bus.reg_write !== 1'b1 || {bus.write_addr, bus.data_in} !== exp) begin errors++; $display("FAIL drain_%0d got rw=%b %h want 1 %h", i, bus.reg_write, {bus.write_addr, bus.data_in}, exp); end
            checks++; if (bus.pending !== CW'(3 - i)) begin errors++; $display("FAIL drain_pending_%0d got %0d want %0d", i, bus.pending, 3 - i); end
        end
        tick();
        checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL drain_done got rw=%b empty=%b want 0/1", bus.reg_write, bus.empty); end
    endtask

    task automatic test_back_to_back;
        int budget;
        wr_log.delete();
        exp_q.delete();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA0;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 32'hB0;
        exp_q.push_back({5'd1, 32'hA0}); exp_q.push_back({5'd2, 32'hB0});
        tick();
        bus.alu_addr = 5'd3; bus.alu_data = 32'hA1;
        bus.mem_addr = 5'd4; bus.mem_data = 32'hB1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_mem_ready2 got %b want 1", bus.mem_ready); end
        exp_q.push_back({5'd3, 32'hA1}); exp_q.push_back({5'd4, 32'hB1});
        tick();
        bus.alu_addr = 5'd5; bus.alu_data = 32'hA2;
        bus.mem_addr = 5'd6; bus.mem_data = 32'hB2;
        checks++; if (bus.pending !== CW'(3) || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_refuse got pend=%0d mem_ready=%b want 3/0", bus.pending, bus.mem_ready); end
        exp_q.push_back({5'd5, 32'hA2});
        tick();
        idle_inputs();
        budget = 0;
        while (bus.empty !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        checks++; if (budget >= 20) begin errors++; $display("FAIL b2b_timeout got empty=%b want 1 within 20 cycles", bus.empty); end
        checks++; if (wr_log.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", wr_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            checks++; if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order_%0d got %h want %h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_drain;
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = AW'(20 + i); bus.alu_data = DW'(32'h200 + i);
            tick();
        end
        idle_inputs();
        bus.wb_hold = 1'b0;
        wr_log.delete();
        tick();
        checks++; if (bus.reg_write !== 1'b1 || bus.pending !== CW'(2)) begin errors++; $display("FAIL mid_drain_start got rw=%b pend=%0d want 1/2", bus.reg_write, bus.pending); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.reg_write !== 1'b0 || bus.pending !== CW'(0) || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_reset got rw=%b pend=%0d empty=%b want 0/0/1", bus.reg_write, bus.pending, bus.empty); end
        checks++; if (bus.write_addr !== 5'd0 || bus.data_in !== 32'h0) begin errors++; $display("FAIL mid_reset_out got addr=%0d data=%h want 0/0", bus.write_addr, bus.data_in); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.reg_write !== 1'b0 || bus.pending !== CW'(0)) begin errors++; $display("FAIL post_reset_%0d got rw=%b pend=%0d want 0/0", i, bus.reg_write, bus.pending); end
        end
        checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL post_reset_writes got %0d want 0", wr_log.size()); end
    endtask

    task automatic test_forwarding;
        bus.wb_hold = 1'b1;
        bus.fwd_addr = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'hA;
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %b want 0", bus.fwd_hit); end
        tick();
        bus.alu_data = 32'hB;
        checks++; if (bus.fwd_hit !== FWD || bus.fwd_data !== (FWD ? 32'hA : 32'h0)) begin errors++; $display("FAIL fwd_one got hit=%b data=%h want %b", bus.fwd_hit, bus.fwd_data, FWD); end
        tick();
        idle_inputs();
        checks++; if (bus.fwd_hit !== FWD || bus.fwd_data !== (FWD ? 32'hB : 32'h0)) begin errors++; $display("FAIL fwd_newest got hit=%b data=%h want %b", bus.fwd_hit, bus.fwd_data, FWD); end
        bus.fwd_addr = 5'd8;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss got hit=%b data=%h want 0/0", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_addr = 5'd7;
        bus.wb_hold = 1'b0;
        tick();
        checks++; if (bus.fwd_hit !== FWD || bus.fwd_data !== (FWD ? 32'hB : 32'h0)) begin errors++; $display("FAIL fwd_fifo_over_out got hit=%b data=%h want %b", bus.fwd_hit, bus.fwd_data, FWD); end
        tick();
        checks++; if (bus.reg_write !== 1'b1 || bus.fwd_hit !== FWD || bus.fwd_data !== (FWD ? 32'hB : 32'h0)) begin errors++; $display("FAIL fwd_out_reg got rw=%b hit=%b data=%h want 1/%b", bus.reg_write, bus.fwd_hit, bus.fwd_data, FWD); end
        tick();
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_gone got %b want 0", bus.fwd_hit); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous();
        test_fill_hold();
        test_back_to_back();
        test_reset_mid_drain();
        test_forwarding();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
